// File: rtl/r2r_interp_softmute.sv
// R2R ladder driver: linear OSR-step interpolation between player samples,
// followed by a tick-paced soft-mute gain ramp and a registered DAC code.
module r2r_interp_softmute #(
   parameter int unsigned OSR     = 8,
   parameter int unsigned SUB_DIV = 283
) (
   input  logic       ACLK,
   input  logic       ARESETN,
   input  logic [7:0] sample_in,
   input  logic       sample_tick,
   input  logic       mute,
   output logic [7:0] DAC,
   output logic       muted,
   output logic       ramp_busy
);

   localparam int unsigned KW       = $clog2(OSR);
   localparam int unsigned SW       = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
   localparam int unsigned PW       = KW + 10;
   localparam int unsigned GW       = 13;
   localparam int unsigned GAIN_MAX = 16;

   typedef enum logic [1:0] {
      ST_MUTED     = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_UNMUTED   = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } state_e;

   logic [7:0]          prev_q;
   logic [7:0]          cur_q;
   logic [KW-1:0]       k_q;
   logic [SW-1:0]       sub_ctr_q;
   logic [4:0]          gain_q;
   logic [4:0]          gain_d;
   state_e              state_q;
   state_e              state_d;
   logic [7:0]          dac_q;
   logic                muted_q;
   logic                busy_q;

   logic signed [8:0]    delta_c;
   logic signed [PW-1:0] prod_c;
   logic [7:0]           interp_c;
   logic signed [8:0]    s_c;
   logic signed [GW-1:0] scaled_c;
   logic [7:0]           out_c;

   // Segment capture and sub-step sequencing; a tick always resyncs the segment.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         prev_q    <= 8'h80;
         cur_q     <= 8'h80;
         k_q       <= '0;
         sub_ctr_q <= '0;
      end else if (sample_tick) begin
         prev_q    <= cur_q;
         cur_q     <= sample_in;
         k_q       <= '0;
         sub_ctr_q <= '0;
      end else if (sub_ctr_q == SW'(SUB_DIV - 1)) begin
         sub_ctr_q <= '0;
         if (k_q != KW'(OSR - 1)) begin
            k_q <= k_q + KW'(1);
         end
      end else begin
         sub_ctr_q <= sub_ctr_q + SW'(1);
      end
   end

   // Interpolation (floor shift stays inside [prev,cur]) and gain scaling about midscale.
   always_comb begin
      delta_c  = $signed({1'b0, cur_q}) - $signed({1'b0, prev_q});
      prod_c   = PW'(delta_c) * PW'($signed({1'b0, k_q}));
      interp_c = 8'(PW'($signed({1'b0, prev_q})) + (prod_c >>> KW));
      s_c      = $signed({1'b0, interp_c}) - 9'sd128;
      scaled_c = GW'(s_c) * GW'($signed({1'b0, gain_q}));
      out_c    = 8'(13'sd128 + (scaled_c >>> 4));
   end

   // Gain only moves on ticks; direction follows the mute level of that cycle.
   always_comb begin
      gain_d  = gain_q;
      state_d = state_q;
      if (sample_tick) begin
         if (mute && (gain_q != 5'd0)) begin
            gain_d = gain_q - 5'd1;
         end else if (!mute && (gain_q != 5'(GAIN_MAX))) begin
            gain_d = gain_q + 5'd1;
         end
      end
      case (state_q)
         ST_UNMUTED: begin
            if (mute) state_d = ST_RAMP_DOWN;
         end
         ST_MUTED: begin
            if (!mute) state_d = ST_RAMP_UP;
         end
         ST_RAMP_DOWN: begin
            if (!mute) begin
               state_d = (gain_d == 5'(GAIN_MAX)) ? ST_UNMUTED : ST_RAMP_UP;
            end else if (gain_d == 5'd0) begin
               state_d = ST_MUTED;
            end
         end
         ST_RAMP_UP: begin
            if (mute) begin
               state_d = (gain_d == 5'd0) ? ST_MUTED : ST_RAMP_DOWN;
            end else if (gain_d == 5'(GAIN_MAX)) begin
               state_d = ST_UNMUTED;
            end
         end
         default: state_d = ST_MUTED;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         gain_q  <= 5'd0;
         state_q <= ST_MUTED;
         dac_q   <= 8'h80;
         muted_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         gain_q  <= gain_d;
         state_q <= state_d;
         dac_q   <= out_c;
         muted_q <= (state_d == ST_MUTED);
         busy_q  <= (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
      end
   end

   assign DAC       = dac_q;
   assign muted     = muted_q;
   assign ramp_busy = busy_q;

endmodule

// File: tb/tb_r2r_interp_softmute.sv
// Bench for r2r_interp_softmute: directed scenarios plus random ticks/mute,
// all checked against an arithmetic model of segment timing, interpolation and gain.
module tb_r2r_interp_softmute;

   localparam int unsigned OSR     = 8;
   localparam int unsigned SUB_DIV = 4;

   logic       ACLK = 1'b0;
   logic       ARESETN;
   logic [7:0] sample_in;
   logic       sample_tick;
   logic       mute;
   logic [7:0] DAC;
   logic       muted;
   logic       ramp_busy;

   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state: samples, cycles since last tick, gain.
   int   m_prev, m_cur, m_cyc, m_gain;
   int   exp_dac;
   logic exp_muted, exp_busy;

   r2r_interp_softmute #(.OSR(OSR), .SUB_DIV(SUB_DIV)) dut (
      .ACLK        (ACLK),
      .ARESETN     (ARESETN),
      .sample_in   (sample_in),
      .sample_tick (sample_tick),
      .mute        (mute),
      .DAC         (DAC),
      .muted       (muted),
      .ramp_busy   (ramp_busy)
   );

   always #5 ACLK = ~ACLK;

   function automatic int floordiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int model_out();
      int k, ip;
      k = m_cyc / int'(SUB_DIV);
      if (k > int'(OSR) - 1) k = int'(OSR) - 1;
      ip = m_prev + floordiv((m_cur - m_prev) * k, int'(OSR));
      return 128 + floordiv((ip - 128) * m_gain, 16);
   endfunction

   task automatic model_reset();
      m_prev = 128; m_cur = 128; m_cyc = 0; m_gain = 0;
      exp_dac = 128; exp_muted = 1'b1; exp_busy = 1'b0;
   endtask

   // One clock: drive inputs, advance the model at the edge, return at the falling edge.
   task automatic step(input logic t, input logic [7:0] s, input logic m);
      sample_tick = t; sample_in = s; mute = m;
      @(posedge ACLK);
      exp_dac = model_out();
      if (t) begin
         m_prev = m_cur; m_cur = int'(s); m_cyc = 0;
         if (m) m_gain = (m_gain > 0) ? m_gain - 1 : 0;
         else   m_gain = (m_gain < 16) ? m_gain + 1 : 16;
      end else if (m_cyc < 100000) begin
         m_cyc = m_cyc + 1;
      end
      exp_muted = m && (m_gain == 0);
      exp_busy  = m ? (m_gain != 0) : (m_gain != 16);
      @(negedge ACLK);
      sample_tick = 1'b0;
   endtask

   task automatic idle(input int n, input logic m);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, m);
   endtask

   task automatic test_reset();
      ARESETN = 1'b0; sample_tick = 1'b0; sample_in = 8'h00; mute = 1'b0;
      model_reset();
      repeat (3) @(negedge ACLK);
      n_tests++;
      if (DAC !== 8'h80) begin n_fail++; $display("FAIL reset_dac: got %02h want 80", DAC); end
      n_tests++;
      if (muted !== 1'b1) begin n_fail++; $display("FAIL reset_muted: got %b want 1", muted); end
      n_tests++;
      if (ramp_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ramp_busy); end
      ARESETN = 1'b1;
   endtask

   task automatic test_rampup();
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 3; j++) begin
            step(j == 0, 8'h80, 1'b0);
            n_tests++;
            if ({DAC, muted, ramp_busy} !== {8'h80, exp_muted, exp_busy}) begin
               n_fail++;
               $display("FAIL rampup tick=%0d: dac/muted/busy=%02h/%b/%b want 80/%b/%b",
                        i, DAC, muted, ramp_busy, exp_muted, exp_busy);
            end
            if (i == 0 && j == 0) begin
               n_tests++;
               if (muted !== 1'b0) begin n_fail++; $display("FAIL rampup_muted_fall: got %b want 0", muted); end
            end
         end
      end
      n_tests++;
      if ({muted, ramp_busy} !== 2'b00) begin
         n_fail++; $display("FAIL rampup_done: muted/busy=%b/%b want 0/0", muted, ramp_busy);
      end
   endtask

   task automatic test_interp();
      logic [7:0] want;
      step(1'b1, 8'h90, 1'b0);
      for (int n = 1; n <= 40; n++) begin
         step(1'b0, 8'h00, 1'b0);
         n_tests++;
         if (DAC !== 8'(exp_dac)) begin
            n_fail++; $display("FAIL interp_model n=%0d: got %02h want %02h", n, DAC, 8'(exp_dac));
         end
         want = 8'h00;
         case (n)
            1:  want = 8'h80;
            5:  want = 8'h82;
            9:  want = 8'h84;
            28: want = 8'h8C;
            29: want = 8'h8E;
            40: want = 8'h8E;
            default: want = 8'h00;
         endcase
         if (want != 8'h00) begin
            n_tests++;
            if (DAC !== want) begin n_fail++; $display("FAIL interp_up n=%0d: got %02h want %02h", n, DAC, want); end
         end
      end
   endtask

   task automatic test_negdelta();
      logic [7:0] want;
      step(1'b1, 8'h83, 1'b0);
      idle(40, 1'b0);
      step(1'b1, 8'h80, 1'b0);
      for (int n = 1; n <= 40; n++) begin
         step(1'b0, 8'h00, 1'b0);
         n_tests++;
         if (DAC !== 8'(exp_dac)) begin
            n_fail++; $display("FAIL negdelta_model n=%0d: got %02h want %02h", n, DAC, 8'(exp_dac));
         end
         want = 8'h00;
         case (n)
            1:  want = 8'h83;
            5:  want = 8'h82;
            21: want = 8'h81;
            40: want = 8'h80;
            default: want = 8'h00;
         endcase
         if (want != 8'h00) begin
            n_tests++;
            if (DAC !== want) begin n_fail++; $display("FAIL negdelta n=%0d: got %02h want %02h", n, DAC, want); end
         end
      end
   endtask

   task automatic test_tick_on_wrap();
      logic [7:0] want;
      step(1'b1, 8'h40, 1'b0);
      idle(40, 1'b0);
      step(1'b1, 8'hC0, 1'b0);
      idle(int'(SUB_DIV) - 1, 1'b0);
      step(1'b1, 8'h10, 1'b0);
      for (int n = 1; n <= 6; n++) begin
         step(1'b0, 8'h00, 1'b0);
         want = 8'h00;
         case (n)
            2: want = 8'hC0;
            4: want = 8'hC0;
            5: want = 8'hAA;
            default: want = 8'h00;
         endcase
         if (want != 8'h00) begin
            n_tests++;
            if (DAC !== want) begin n_fail++; $display("FAIL tick_wrap n=%0d: got %02h want %02h", n, DAC, want); end
         end
      end
   endtask

   task automatic test_gain();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'hFF, 1'b1);
         idle(3, 1'b1);
         n_tests++;
         if ({muted, ramp_busy} !== 2'b01) begin
            n_fail++; $display("FAIL gain_down_flags i=%0d: muted/busy=%b/%b want 0/1", i, muted, ramp_busy);
         end
      end
      n_tests++;
      if (DAC !== 8'hBF) begin n_fail++; $display("FAIL gain8_ff: got %02h want bf", DAC); end
      step(1'b1, 8'h00, 1'b0); idle(3, 1'b0);
      step(1'b1, 8'h00, 1'b1); idle(3, 1'b1);
      n_tests++;
      if (DAC !== 8'h40) begin n_fail++; $display("FAIL gain8_00: got %02h want 40", DAC); end
      for (int i = 0; i < 8; i++) begin step(1'b1, 8'h00, 1'b0); idle(3, 1'b0); end
      n_tests++;
      if ({DAC, ramp_busy} !== {8'h00, 1'b0}) begin
         n_fail++; $display("FAIL gain16_00: dac/busy=%02h/%b want 00/0", DAC, ramp_busy);
      end
      for (int i = 0; i < 2; i++) begin step(1'b1, 8'hFF, 1'b0); idle(3, 1'b0); end
      n_tests++;
      if (DAC !== 8'hFF) begin n_fail++; $display("FAIL gain16_ff: got %02h want ff", DAC); end
      n_tests++;
      if (DAC !== 8'(exp_dac)) begin n_fail++; $display("FAIL gain_model: got %02h want %02h", DAC, 8'(exp_dac)); end
   endtask

   task automatic test_reversal();
      logic [7:0] want;
      for (int i = 0; i < 2; i++) begin step(1'b1, 8'h00, 1'b0); idle(3, 1'b0); end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'h00, 1'b1); idle(3, 1'b1);
         want = 8'(128 - 8 * (15 - i));
         n_tests++;
         if ({DAC, ramp_busy} !== {want, 1'b1}) begin
            n_fail++; $display("FAIL reversal_down i=%0d: dac/busy=%02h/%b want %02h/1", i, DAC, ramp_busy, want);
         end
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'h00, 1'b0); idle(3, 1'b0);
         want = 8'(128 - 8 * (12 + i));
         n_tests++;
         if ({DAC, ramp_busy} !== {want, (i < 4) ? 1'b1 : 1'b0}) begin
            n_fail++; $display("FAIL reversal_up i=%0d: dac/busy=%02h/%b want %02h/%b",
                               i, DAC, ramp_busy, want, (i < 4));
         end
      end
   endtask

   task automatic test_async_reset();
      step(1'b1, 8'h20, 1'b0);
      idle(6, 1'b0);
      n_tests++;
      if ({DAC, muted} !== {8'(exp_dac), 1'b0}) begin
         n_fail++; $display("FAIL pre_reset: dac/muted=%02h/%b want %02h/0", DAC, muted, 8'(exp_dac));
      end
      @(posedge ACLK);
      #3 ARESETN = 1'b0;
      #1;
      n_tests++;
      if ({DAC, muted, ramp_busy} !== {8'h80, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL async_reset: dac/muted/busy=%02h/%b/%b want 80/1/0", DAC, muted, ramp_busy);
      end
      @(negedge ACLK);
      model_reset();
      ARESETN = 1'b1;
   endtask

   task automatic test_random();
      int   gap;
      logic m, t;
      gap = 1; m = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         gap = gap - 1;
         t = (gap == 0);
         if (t) gap = int'($urandom_range(1, 45));
         if ($urandom_range(0, 59) == 0) m = ~m;
         step(t, 8'($urandom), m);
         n_tests++;
         if ({DAC, muted, ramp_busy} !== {8'(exp_dac), exp_muted, exp_busy}) begin
            n_fail++;
            $display("FAIL random c=%0d: dac/muted/busy=%02h/%b/%b want %02h/%b/%b",
                     c, DAC, muted, ramp_busy, 8'(exp_dac), exp_muted, exp_busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rampup();
      test_interp();
      test_negdelta();
      test_tick_on_wrap();
      test_gain();
      test_reversal();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
